// File: rtl/seq_mul_param_if.sv
`default_nettype none
// ============================================================================
// Module   : seq_mul_param_if
// Brief    : Operand/handshake/result bundle for the seq_mul_param multiplier.
// Revision : 1.0 - initial release
// ============================================================================
interface seq_mul_param_if #(
    parameter int WIDTH = 16
) ();
    logic                 start;
    logic                 signed_mode;
    logic [WIDTH-1:0]     a_in;
    logic [WIDTH-1:0]     b_in;
    logic                 busy;
    logic                 done;
    logic [2*WIDTH-1:0]   product;

    modport master (
        output start, signed_mode, a_in, b_in,
        input  busy, done, product
    );

    modport slave (
        input  start, signed_mode, a_in, b_in,
        output busy, done, product
    );
endinterface
`default_nettype wire

// File: rtl/seq_mul_param.sv
`default_nettype none
// ============================================================================
// Module   : seq_mul_param
// Brief    : Sequential shift-add multiplier, unsigned/signed, early termination.
// Revision : 1.0 - initial release
// ============================================================================
module seq_mul_param #(
    parameter int WIDTH      = 16,
    parameter bit EARLY_TERM = 1'b1
) (
    input  wire logic          clk,
    input  wire logic          rst,
    seq_mul_param_if.slave     bus
);

    localparam int               c_CW    = $clog2(WIDTH + 1);
    localparam logic [c_CW-1:0]  c_LAST  = c_CW'(WIDTH - 1);
    localparam logic [c_CW-1:0]  c_STEPS = c_CW'(WIDTH);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_CALC = 2'd1;
    localparam logic [1:0] c_DONE = 2'd2;

    logic [1:0]           r_state;
    logic [2*WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]     r_b;
    logic [2*WIDTH-1:0]   r_p;
    logic [c_CW-1:0]      r_cnt;
    logic                 r_neg;
    logic [2*WIDTH-1:0]   r_product;

    logic                 w_a_neg;
    logic                 w_b_neg;
    logic [WIDTH-1:0]     w_a_mag;
    logic [WIDTH-1:0]     w_b_mag;
    logic [2*WIDTH-1:0]   w_p_next;
    logic [WIDTH-1:0]     w_b_next;
    logic                 w_stop_now;
    logic                 w_last;

    // The most negative value negates to itself, which read unsigned is its magnitude.
    assign w_a_neg   = bus.signed_mode & bus.a_in[WIDTH-1];
    assign w_b_neg   = bus.signed_mode & bus.b_in[WIDTH-1];
    assign w_a_mag   = w_a_neg ? (~bus.a_in + WIDTH'(1)) : bus.a_in;
    assign w_b_mag   = w_b_neg ? (~bus.b_in + WIDTH'(1)) : bus.b_in;

    assign w_p_next   = r_b[0] ? (r_p + r_a) : r_p;
    assign w_b_next   = r_b >> 1;
    assign w_stop_now = (EARLY_TERM && (r_b == '0)) || (r_cnt >= c_STEPS);
    assign w_last     = (r_cnt == c_LAST) || (EARLY_TERM && (w_b_next == '0));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= c_IDLE;
            r_a       <= '0;
            r_b       <= '0;
            r_p       <= '0;
            r_cnt     <= '0;
            r_neg     <= 1'b0;
            r_product <= '0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (bus.start) begin
                        r_a     <= {{WIDTH{1'b0}}, w_a_mag};
                        r_b     <= w_b_mag;
                        r_p     <= '0;
                        r_cnt   <= '0;
                        r_neg   <= w_a_neg ^ w_b_neg;
                        r_state <= c_CALC;
                    end
                end
                c_CALC: begin
                    if (w_stop_now) begin
                        r_product <= r_neg ? -r_p : r_p;
                        r_state   <= c_DONE;
                    end else begin
                        r_p   <= w_p_next;
                        r_a   <= r_a << 1;
                        r_b   <= w_b_next;
                        r_cnt <= r_cnt + c_CW'(1);
                        // Finish on the same edge as the final add to save a cycle.
                        if (w_last) begin
                            r_product <= r_neg ? -w_p_next : w_p_next;
                            r_state   <= c_DONE;
                        end
                    end
                end
                c_DONE: begin
                    r_state <= c_IDLE;
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    assign bus.busy    = (r_state != c_IDLE);
    assign bus.done    = (r_state == c_DONE);
    assign bus.product = r_product;

endmodule
`default_nettype wire
